multiply: RTL

- Iterative radix-2 shift-add unsigned multiplier for the FPU datapath; the companion to the iterative divider.
- Computes the full 2*WIDTH-bit product of two WIDTH-bit operands in exactly WIDTH busy cycles, one partial product per cycle.
- Uses the same start/busy/valid handshake as the divider, so the FPU control FSM can drive both units identically. Main use: mantissa products.

---
 rtl/multiply_pkg.sv | 14 +
 rtl/multiply.sv | 111 +++++++++++
 2 files changed

// File: rtl/multiply_pkg.sv
// Shared FPU constants for the iterative arithmetic units.
// The multiplier and the divider both take their default operand width
// from MANT_W, so every FPU instance of the two units agrees on width.
package multiply_pkg;

    // Mantissa width used to instantiate the iterative mul/div units.
    localparam int MANT_W = 8;

    // Width of a counter that must index 0 .. w-1.
    function automatic int iter_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/multiply.sv
// Iterative radix-2 shift-add unsigned multiplier.
// Produces the full 2*WIDTH-bit product in exactly WIDTH busy cycles,
// one partial product per cycle, using the same start/busy/valid
// handshake as the iterative divider.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (priority over start)
//   start - one-cycle pulse; latches x/y and begins (or restarts) a multiply
//   busy  - calculation in progress
//   valid - p and ovf hold a completed result
//   x, y  - unsigned multiplicand / multiplier, sampled on the start edge
//   p     - product x*y
//   ovf   - upper half of p is nonzero
module multiply
    import multiply_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               valid,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] p,
    output logic               ovf
);

    localparam int CW = iter_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy_q,  busy_d;
    logic               valid_q, valid_d;
    logic [2*WIDTH-1:0] p_q,     p_d;
    logic               ovf_q,   ovf_d;
    logic [WIDTH-1:0]   x1_q,    x1_d;
    logic [WIDTH:0]     acc_q,   acc_d;
    logic [WIDTH-1:0]   mq_q,    mq_d;
    logic [CW-1:0]      i_q,     i_d;

    // One shift-add step. The carry lands in acc[WIDTH] before the shift
    // and moves down, so acc_nx[WIDTH] is always 0 afterwards.
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_nx;
    logic [WIDTH-1:0]   mq_nx;

    always_comb begin
        sum             = acc_q + (mq_q[0] ? {1'b0, x1_q} : '0);
        {acc_nx, mq_nx} = {1'b0, sum, mq_q[WIDTH-1:1]};

        busy_d  = busy_q;
        valid_d = valid_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        x1_d    = x1_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        i_d     = i_q;

        if (start) begin
            // Restart from any state; an in-flight operation is dropped.
            valid_d = 1'b0;
            busy_d  = 1'b1;
            i_d     = '0;
            x1_d    = x;
            acc_d   = '0;
            mq_d    = y;
        end else if (busy_q) begin
            acc_d = acc_nx;
            mq_d  = mq_nx;
            if (i_q == LAST) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                p_d     = {acc_nx[WIDTH-1:0], mq_nx};
                ovf_d   = |acc_nx[WIDTH-1:0];
            end else begin
                i_d = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            x1_q    <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            i_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            x1_q    <= x1_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            i_q     <= i_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign p     = p_q;
    assign ovf   = ovf_q;

endmodule
